microop_sequencer: RTL
======================

MICROOP_SEQUENCER -- requirements
Module: microop_sequencer

Interface
REQ-001 Parameter STEP_W, default 3: width of the micro-op step index; maximum instruction length is 2**STEP_W steps.
REQ-002 Parameter WRAP_MODE, default 0: 0 = length-bounded, stop after last step; 1 = free-running, length ignored, step wraps.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start_valid  in  1  request to begin a new instruction.
REQ-006 start_len  in  STEP_W  index of the instruction's last step (length minus one); sampled on accept.
REQ-007 start_ready  out  1  sequencer can accept start this cycle.
REQ-008 stall  in  1  hold the current step; no advance, no retire.
REQ-009 abort  in  1  cancel the current instruction immediately.
REQ-010 step  out  STEP_W  current micro-op step index.
REQ-011 busy  out  1  an instruction is executing (state RUN).
REQ-012 step_first  out  1  busy and step == 0.
REQ-013 step_last  out  1  busy and step == len_q.
REQ-014 done  out  1  one-cycle pulse in the cycle the last step retires.

Function
REQ-015 Two states, IDLE and RUN; busy SHALL equal (state == RUN); len_q SHALL be an internal STEP_W register.
REQ-016 A step retires in a RUN cycle with stall=0 and abort=0.
REQ-017 start_ready SHALL be combinational: 1 in IDLE; 1 in RUN when step_last is high and the step retires; in WRAP_MODE=1 additionally 1 in every RUN cycle; always 0 when abort=1.
REQ-018 Accept = start_valid AND start_ready; on accept, next cycle: state=RUN, step=0, len_q=start_len (WRAP_MODE=1: len_q=all ones).
REQ-019 RUN, retire, step != len_q, no accept: step increments by 1 next cycle.
REQ-020 RUN, retire, step == len_q: done=1 this cycle (combinational); next cycle RUN with step=0 if accept occurred, else IDLE with step=0 (WRAP_MODE=0) or RUN with step=0 (WRAP_MODE=1, wrap).
REQ-021 Back-to-back instructions SHALL have zero bubble: the cycle after a retiring last step is step 0 of the next instruction.
REQ-022 start_len=0: single-step instruction; step_first and step_last both high; done pulses on its only retiring cycle.
REQ-023 stall=1 in RUN: step, len_q and state hold; done=0; start_ready=0 (WRAP_MODE=0); stall ignored in IDLE.
REQ-024 abort=1 (highest priority, any state): next cycle IDLE, step=0; done=0 that cycle; a simultaneous start is not accepted.
REQ-025 Step arithmetic is modulo 2**STEP_W; with len_q all ones, step wraps from max to 0 with done asserted.
REQ-026 step_first, step_last, done SHALL be 0 whenever busy=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, step=0, len_q=0; busy, step_first, step_last, done read 0, independent of clk.
REQ-028 Reset mid-instruction SHALL discard it with no done pulse; first edge after rst_n rises sees start_ready=1.

Verification
REQ-029 Reset, start_len=3, start_valid one cycle, no stall -> step 0,1,2,3 on consecutive cycles; done high only with step=3; then IDLE, busy=0.
REQ-030 start_len=2 with stall high while step=1 for 2 cycles -> step sequence 0,1,1,1,2; done once; start_ready low during stalled cycles.
REQ-031 Two instructions len 1 then len 0, start_valid held -> step 0,1,0 with busy continuously 1; done on cycles 2 and 3; step_first and step_last both high on cycle 3.
REQ-032 start_len=5, abort at step=2 with start_valid=1 -> next cycle IDLE, step=0, no done, start not accepted; new start accepted the following cycle.
REQ-033 WRAP_MODE=1, STEP_W=3, one start -> step 0..7 then 0 repeating, done on every step=7; start_valid at step=4 -> next step=0.
REQ-034 rst_n asserted between clock edges at step=2 of len 4 -> outputs zero immediately; after release, start accepted on first edge.

Source files
------------

// File: rtl/microop_sequencer.sv
// ---------------------------------------------------------------------------
// microop_sequencer
//   Steps through the micro-op indices of one instruction at a time. An
//   instruction is started with a start_valid/start_ready handshake that
//   carries the index of its last step; the sequencer then walks step 0..len,
//   one step per non-stalled cycle, pulsing done as the last step retires.
//   Back-to-back instructions follow each other with no idle cycle.
//   WRAP_MODE=1 turns it into a free-running counter over the full step range.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   start_valid  : request to begin a new instruction
//   start_len    : index of the instruction's last step, sampled on accept
//   start_ready  : sequencer can accept a start this cycle (combinational)
//   stall        : hold the current step (no advance, no retire)
//   abort        : cancel the current instruction, highest priority
//   step         : current micro-op step index
//   busy         : an instruction is executing
//   step_first   : busy and step == 0
//   step_last    : busy and step == last index
//   done         : one-cycle pulse while the last step retires
// ---------------------------------------------------------------------------
module microop_sequencer #(
  parameter int unsigned STEP_W    = 3,
  parameter bit          WRAP_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  input  logic [STEP_W-1:0] start_len,
  output logic              start_ready,
  input  logic              stall,
  input  logic              abort,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              step_first,
  output logic              step_last,
  output logic              done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] r_len;

  logic w_run;
  logic w_at_last;
  logic w_retire;
  logic w_ready;
  logic w_accept;

  // Handshake and retire decode from the current registered state
  always_comb begin
    w_run     = (r_state == ST_RUN);
    w_at_last = w_run && (r_step == r_len);
    w_retire  = w_run && !stall && !abort;
    if (abort) begin
      w_ready = 1'b0;
    end else if (!w_run) begin
      w_ready = 1'b1;
    end else if (WRAP_MODE) begin
      // Free-running: a new start may restart the count in any cycle
      w_ready = 1'b1;
    end else begin
      // Length-bounded: only take the next start as the last step leaves,
      // which gives zero-bubble chaining
      w_ready = w_at_last && w_retire;
    end
    w_accept = start_valid && w_ready;
  end

  // Sequencer state: abort beats accept beats retire beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= {STEP_W{1'b0}};
      r_len   <= {STEP_W{1'b0}};
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_step  <= {STEP_W{1'b0}};
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_step  <= {STEP_W{1'b0}};
      r_len   <= WRAP_MODE ? {STEP_W{1'b1}} : start_len;
    end else if (w_retire) begin
      if (w_at_last) begin
        r_state <= WRAP_MODE ? ST_RUN : ST_IDLE;
        r_step  <= {STEP_W{1'b0}};
      end else begin
        r_step  <= r_step + {{(STEP_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_state <= r_state;
      r_step  <= r_step;
    end
  end

  assign start_ready = w_ready;
  assign step        = r_step;
  assign busy        = w_run;
  assign step_first  = w_run && (r_step == {STEP_W{1'b0}});
  assign step_last   = w_at_last;
  assign done        = w_retire && w_at_last;

endmodule
